// File: rtl/scratchpad_ram.sv
// Scratchpad RAM responder for the core-side req/ack memory bus.
// Latency: ack is sampled high WAIT_STATES+1 edges after the req-sampling edge (min 1).
// Backpressure: req is held by the initiator until ack; one transaction per WAIT_STATES+2 cycles.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   addr, wdata, we, be transaction qualifiers, sampled with req in IDLE
//   req                 transaction request, held until ack
//   rdata, err, ack     one-cycle completion pulse with read data / error qualifier
//   busy                high while a transaction is in flight (WAIT or RESP)
//   parity_err          sticky parity-error flag (constant 0 unless parity is built in)
//
// Optional feature: define SCRATCHPAD_PARITY_EN to store one even-parity bit per byte
// and flag corrupted words on in-range reads.

module scratchpad_ram #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic                  req,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int         IW   = $clog2(DEPTH);
  localparam logic [3:0] WS_L = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Latched transaction qualifiers
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [3:0]            be_q;

  // Response registers
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Storage (not reset)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Transaction view. With zero wait states the array update happens on the
  // very edge that samples req, so the live bus is used in IDLE and the
  // latched copy otherwise.
  logic [ADDR_WIDTH-1:0] t_addr;
  logic [DATA_WIDTH-1:0] t_wdata;
  logic                  t_we;
  logic [3:0]            t_be;
  logic [IW-1:0]         t_idx;
  logic                  t_inr;
  logic                  take;
  logic                  enter_resp;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  par_bad;
  logic                  unused_addr_lsbs;

  assign t_addr  = (state_q == S_IDLE) ? addr  : addr_q;
  assign t_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
  assign t_we    = (state_q == S_IDLE) ? we    : we_q;
  assign t_be    = (state_q == S_IDLE) ? be    : be_q;

  // BASE_ADDR is aligned to the region size, so the range check reduces to
  // comparing the address bits above the word index.
  assign t_idx = t_addr[IW+1:2];
  assign t_inr = (t_addr[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2]);

  // Byte offset within the word is meaningless on this bus.
  assign unused_addr_lsbs = ^t_addr[1:0];

  assign take    = (state_q == S_IDLE) && req;
  assign rd_word = mem[t_idx];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = WS_L;
          state_d = (WS_L == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Leave on the edge where the counter reaches zero.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // rst_n gates the array write because the array itself has no reset: a req
  // held during reset with zero wait states must not reach the storage.
  assign mem_wr = enter_resp && rst_n && t_we && t_inr;

  // ---------------------------------------------------------------------------
  // Optional parity
  // ---------------------------------------------------------------------------
`ifdef SCRATCHPAD_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_calc;
  logic       par_err_q;

  always_comb begin
    par_calc = '0;
    for (int b = 0; b < 4; b++) begin
      par_calc[b] = ^rd_word[8*b +: 8];
    end
  end

  assign par_bad = |(par_calc ^ par_mem[t_idx]);

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (t_be[b]) begin
          par_mem[t_idx][b] <= ^t_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (enter_resp && !t_we && t_inr && par_bad) begin
      par_err_q <= 1'b1;
    end
  end

  assign parity_err = par_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Response data
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (!t_inr) begin
      err_d = 1'b1;
    end else if (!t_we) begin
      rdata_d = rd_word;
      err_d   = par_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write: only enabled bytes change; be=0 is a legal no-op write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (t_be[b]) begin
          mem[t_idx][8*b +: 8] <= t_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, qualifier latch and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
        be_q    <= be;
      end
      // rdata/err hold until the next transaction reaches RESP.
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign ack   = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_scratchpad_ram.sv
// Testbench for scratchpad_ram: two instances (WAIT_STATES=1 and 0), random and
// directed transactions, transaction-level reference model with a per-cycle checker.
// Prints one summary line at the end.

module tb_scratchpad_ram;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;
  localparam int          NDUT  = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic        we    [NDUT];
  logic [3:0]  be    [NDUT];
  logic        req   [NDUT];
  logic [31:0] rdata [NDUT];
  logic        ack   [NDUT];
  logic        err   [NDUT];
  logic        busy  [NDUT];
  logic        perr  [NDUT];

  int total;
  int bad;
  int cyc;
  int ack_cnt [NDUT];

  // Instance 0 has one wait state, instance 1 has none.
  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  scratchpad_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr[0]), .wdata(wdata[0]), .we(we[0]), .be(be[0]),
    .req(req[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]),
    .parity_err(perr[0])
  );

  scratchpad_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr[1]), .wdata(wdata[1]), .we(we[1]), .be(be[1]),
    .req(req[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]),
    .parity_err(perr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: words, per-word "contents known" flag, injected parity
  // corruption mask, and at most one outstanding transaction per instance.
  // ---------------------------------------------------------------------------
  logic [31:0] mm      [NDUT][DEPTH];
  bit          known   [NDUT][DEPTH];
  bit   [3:0]  corrupt [NDUT][DEPTH];
  bit          sticky  [NDUT];

  bit          p_act  [NDUT];
  bit          p_done [NDUT];
  int          p_n    [NDUT];
  int          free_at[NDUT];
  bit          p_we   [NDUT];
  bit          p_inr  [NDUT];
  int          p_idx  [NDUT];
  logic [3:0]  p_be   [NDUT];
  logic [31:0] p_wd   [NDUT];
  logic [31:0] p_rd   [NDUT];
  bit          p_rdk  [NDUT];
  bit          p_err  [NDUT];

  // A request sampled at edge n is acked in the cycle after edge n+WS, the
  // array changes on that same edge, and the next request can be taken at n+WS+2.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        p_act[k]   = 1'b0;
        free_at[k] = 0;
        sticky[k]  = 1'b0;
      end else begin
        if (p_act[k] && cyc > p_n[k] + ws_of(k)) p_act[k] = 1'b0;
        if (!p_act[k] && req[k] && cyc >= free_at[k]) begin
          p_act[k]  = 1'b1;
          p_done[k] = 1'b0;
          p_n[k]    = cyc;
          free_at[k] = cyc + ws_of(k) + 2;
          p_we[k]   = we[k];
          p_be[k]   = be[k];
          p_wd[k]   = wdata[k];
          p_inr[k]  = (addr[k] >= BASE) && ({1'b0, addr[k]} < {1'b0, BASE} + 33'(DEPTH * 4));
          p_idx[k]  = p_inr[k] ? int'((addr[k] - BASE) / 4) : 0;
          p_err[k]  = !p_inr[k];
          p_rd[k]   = 32'h0;
          p_rdk[k]  = 1'b1;
          if (p_inr[k] && !we[k]) begin
            p_rd[k]  = mm[k][p_idx[k]];
            p_rdk[k] = known[k][p_idx[k]];
            if (corrupt[k][p_idx[k]] != 4'h0) p_err[k] = 1'b1;
          end
        end
        if (p_act[k] && !p_done[k] && cyc == p_n[k] + ws_of(k)) begin
          p_done[k] = 1'b1;
          if (p_we[k] && p_inr[k]) begin
            for (int b = 0; b < 4; b++) begin
              if (p_be[k][b]) begin
                mm[k][p_idx[k]][8*b +: 8] = p_wd[k][8*b +: 8];
                corrupt[k][p_idx[k]][b] = 1'b0;
              end
            end
            if (p_be[k] == 4'hF) known[k][p_idx[k]] = 1'b1;
          end
          if (!p_we[k] && p_inr[k] && corrupt[k][p_idx[k]] != 4'h0) sticky[k] = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NDUT; k++) begin : cmp
      bit ea;
      bit eb;
      ea = p_act[k] && (cyc == p_n[k] + ws_of(k));
      eb = p_act[k] && (cyc <= p_n[k] + ws_of(k));
      if (ack[k]) ack_cnt[k]++;
      chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(ea));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(eb));
      chk($sformatf("parity_err%0d", k), 32'(perr[k]), 32'(sticky[k]));
      if (ea) begin
        chk($sformatf("err%0d", k), 32'(err[k]), 32'(p_err[k]));
        if (p_rdk[k]) chk($sformatf("rdata%0d", k), rdata[k], p_rd[k]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: one transaction, qualifiers scrambled while the DUT is waiting.
  // lat counts edges from the sampling edge up to the one after which ack shows.
  // ---------------------------------------------------------------------------
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic e,
                     output int lat);
    bit got;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    lat = 0; rd = '0; e = 1'b0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack[k]) begin
        got = 1'b1;
        rd  = rdata[k];
        e   = err[k];
      end else if (lat == 1) begin
        @(negedge clk);
        we[k] = 1'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
        be[k] = 4'($urandom_range(0, 15)); req[k] = 1'($urandom);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL txn_timeout%0d: got no ack expected ack within 40 cycles", k);
    end
    @(negedge clk);
    req[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          ack_t [4];
    int          base_cnt;
    bit          got;

    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int k = 0; k < NDUT; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
      ack_cnt[k] = 0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(ack[0]), 32'h0);
    chk("reset_busy", 32'(busy[0]), 32'h0);
    chk("reset_rdata", rdata[0], 32'h0);
    chk("reset_err", 32'(err[0]), 32'h0);
    chk("reset_parity_err", 32'(perr[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write / read back with one wait state
    txn(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, rd, e, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_err", 32'(e), 32'h0);
    txn(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_err", 32'(e), 32'h0);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdata[0], 32'hDEAD_BEEF);

    // Byte-enable merge
    txn(0, 1'b1, BASE, 32'h1122_3344, 4'hF, rd, e, lat);
    chk("wr_clears_rdata", rd, 32'h0);
    txn(0, 1'b1, BASE, 32'hAABB_CCDD, 4'b0101, rd, e, lat);
    txn(0, 1'b0, BASE, 32'h0, 4'h0, rd, e, lat);
    chk("merge_data", rd, 32'h11BB_33DD);

    // Out-of-range accesses
    txn(0, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, rd, e, lat);
    chk("oor_below_err", 32'(e), 32'h1);
    chk("oor_below_rdata", rd, 32'h0);
    txn(0, 1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'hF, rd, e, lat);
    chk("oor_above_err", 32'(e), 32'h1);
    chk("oor_above_rdata", rd, 32'h0);
    txn(0, 1'b1, 32'h1000_1000, 32'hFFFF_FFFF, 4'hF, rd, e, lat);
    chk("oor_wr_err", 32'(e), 32'h1);
    txn(0, 1'b0, BASE, 32'h0, 4'h0, rd, e, lat);
    chk("oor_wr_no_alias", rd, 32'h11BB_33DD);

    // be=0 write acks cleanly and leaves the word alone
    txn(0, 1'b1, BASE, 32'h5555_5555, 4'h0, rd, e, lat);
    chk("be0_err", 32'(e), 32'h0);
    txn(0, 1'b0, BASE, 32'h0, 4'h0, rd, e, lat);
    chk("be0_unchanged", rd, 32'h11BB_33DD);

    // Zero wait states: single-cycle latency
    txn(1, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, rd, e, lat);
    chk("ws0_latency", 32'(lat), 32'd1);

    // Back-to-back with req held high on the zero-wait instance
    @(negedge clk);
    base_cnt = ack_cnt[1];
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      addr[1]  = BASE + 32'h40 + 32'(i * 4);
      wdata[1] = 32'hB2B0_0000 + 32'(i);
      got = 1'b0;
      for (int j = 0; j < 10 && !got; j++) begin
        @(posedge clk);
        #1;
        if (ack[1]) got = 1'b1;
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL b2b_timeout: got no ack expected ack for write %0d", i);
      end
      ack_t[i] = cyc;
      @(negedge clk);
    end
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_ack_count", 32'(ack_cnt[1] - base_cnt), 32'd4);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd2);
    for (int i = 0; i < 4; i++) begin
      txn(1, 1'b0, BASE + 32'h40 + 32'(i * 4), 32'h0, 4'h0, rd, e, lat);
      chk("b2b_readback", rd, 32'hB2B0_0000 + 32'(i));
    end

    // Reset during WAIT discards the pending write
    txn(0, 1'b1, BASE + 32'h14, 32'h0, 4'hF, rd, e, lat);
    @(negedge clk);
    base_cnt = ack_cnt[0];
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 32'h14; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
    @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy[0]), 32'h1);
    @(negedge clk);
    rst_n  = 1'b0;
    req[0] = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack[0]), 32'h0);
    chk("midrst_busy", 32'(busy[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_ack", 32'(ack_cnt[0] - base_cnt), 32'h0);
    txn(0, 1'b0, BASE + 32'h14, 32'h0, 4'h0, rd, e, lat);
    chk("midrst_word5", rd, 32'h0);

`ifdef SCRATCHPAD_PARITY_EN
    txn(0, 1'b1, BASE + 32'hC, 32'h0F0F_0F0F, 4'hF, rd, e, lat);
    @(negedge clk);
    dut.par_mem[3][0] = ~dut.par_mem[3][0];
    corrupt[0][3][0] = 1'b1;
    txn(0, 1'b0, BASE + 32'hC, 32'h0, 4'h0, rd, e, lat);
    chk("parity_read_err", 32'(e), 32'h1);
    txn(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("parity_clean_err", 32'(e), 32'h0);
    chk("parity_sticky", 32'(perr[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("parity_cleared", 32'(perr[0]), 32'h0);
    txn(0, 1'b1, BASE + 32'hC, 32'h0F0F_0F0F, 4'hF, rd, e, lat);
`endif

    // Random traffic: seed a small window, then mixed reads/writes/out-of-range.
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < NDUT; k++) begin
        txn(k, 1'b1, BASE + 32'(w * 4), $urandom, 4'hF, rd, e, lat);
      end
    end
    repeat (160) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'd4 + 32'($urandom_range(0, 3));
        1:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      endcase
      txn(k, 1'($urandom), a, $urandom, 4'($urandom_range(0, 15)), rd, e, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
